// File: rtl/aemb2_pkg.sv
// Shared encodings for the AEMB2 multi-thread register bank: writeback
// source codes, load lane selects, sweep FSM states and the thread-ID width.
package aemb2_pkg;

  localparam logic [2:0] MUX_NONE = 3'd0;
  localparam logic [2:0] MUX_ALU  = 3'd1;
  localparam logic [2:0] MUX_SFR  = 3'd2;
  localparam logic [2:0] MUX_MUL  = 3'd3;
  localparam logic [2:0] MUX_BSF  = 3'd4;
  localparam logic [2:0] MUX_LD   = 3'd5;
  localparam logic [2:0] MUX_XWB  = 3'd6;
  localparam logic [2:0] MUX_LNK  = 3'd7;

  localparam logic [3:0] SEL_WORD = 4'b1111;
  localparam logic [3:0] SEL_HI   = 4'b1100;
  localparam logic [3:0] SEL_LO   = 4'b0011;
  localparam logic [3:0] SEL_B3   = 4'b1000;
  localparam logic [3:0] SEL_B2   = 4'b0100;
  localparam logic [3:0] SEL_B1   = 4'b0010;
  localparam logic [3:0] SEL_B0   = 4'b0001;

  typedef enum logic [0:0] {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

  // A single-thread bank still carries a one-bit thread ID.
  function automatic int unsigned f_tw(input int unsigned thr);
    return (thr > 32'd2) ? $clog2(thr) : 32'd1;
  endfunction

endpackage

// File: rtl/aemb2_regbank_ram.sv
// 1W3R register storage: synchronous write, asynchronous reads. Each read
// port can be split out into its own 1W1R copy for FPGA RAM inference.
module aemb2_regbank_ram
  import aemb2_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_wa,
  input  logic [31:0]   i_wd,
  input  logic [AW-1:0] i_ra,
  input  logic [AW-1:0] i_rb,
  input  logic [AW-1:0] i_rd,
  output logic [31:0]   o_qa,
  output logic [31:0]   o_qb,
  output logic [31:0]   o_qd
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_qa = r_mem[i_ra];
  assign o_qb = r_mem[i_rb];
  assign o_qd = r_mem[i_rd];

endmodule

// File: rtl/aemb2_regbank.sv
// AEMB2 multi-thread register bank: thread pipeline, writeback mux with load
// lane extraction, optional write-to-read bypass and a post-reset zero sweep.
module aemb2_regbank
  import aemb2_pkg::*;
#(
  parameter int AEMB_THR = 2,
  parameter int AEMB_CLR = 1,
  parameter int AEMB_FWD = 1
) (
  input  logic                          gclk,
  input  logic                          grst,
  input  logic                          dena,
  input  logic [f_tw(AEMB_THR)-1:0]     gpha,
  input  logic [31:0]                   ich_dat,
  input  logic [4:0]                    rd_ex,
  input  logic [2:0]                    mux_ex,
  input  logic [3:0]                    sel_mx,
  input  logic [31:0]                   alu_mx,
  input  logic [31:0]                   sfr_mx,
  input  logic [31:0]                   mul_mx,
  input  logic [31:0]                   bsf_mx,
  input  logic [31:0]                   dwb_mx,
  input  logic [31:0]                   xwb_mx,
  input  logic [31:2]                   rpc_mx,
  output logic [31:0]                   opa_if,
  output logic [31:0]                   opb_if,
  output logic [31:0]                   opd_if,
  output logic                          clr_busy
);

  localparam int TW    = f_tw(AEMB_THR);
  localparam int DEPTH = AEMB_THR * 32;
  localparam int AW    = $clog2(DEPTH);

  logic [TW-1:0] r_tid_of;
  logic [TW-1:0] r_tid_ex;
  logic [TW-1:0] r_tid_mx;
  logic [4:0]    r_rd_mx;
  logic [2:0]    r_mux_mx;
  logic [31:0]   r_opa;
  logic [31:0]   r_opb;
  logic [31:0]   r_opd;
  clr_state_e    r_state;
  logic [AW-1:0] r_cnt;

  logic [31:0]   w_lane;
  logic [31:0]   w_wb;
  logic          w_pipe_we;
  logic [AW-1:0] w_pipe_wa;
  logic          w_clr_we;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_wa;
  logic [31:0]   w_ram_wd;
  logic [4:0]    w_fa;
  logic [4:0]    w_fb;
  logic [4:0]    w_fd;
  logic [AW-1:0] w_ra;
  logic [AW-1:0] w_rb;
  logic [AW-1:0] w_rd;
  logic [31:0]   w_qa;
  logic [31:0]   w_qb;
  logic [31:0]   w_qd;
  logic          w_hit_a;
  logic          w_hit_b;
  logic          w_hit_d;
  logic [31:0]   w_opa_nx;
  logic [31:0]   w_opb_nx;
  logic [31:0]   w_opd_nx;
  logic          w_unused;

  // Entry index is {thread, reg}; a single-thread bank drops the thread bit.
  function automatic logic [AW-1:0] f_idx(input logic [TW-1:0] tid, input logic [4:0] rn);
    logic [TW+4:0] full;
    full = {tid, rn};
    return full[AW-1:0];
  endfunction

  function automatic logic [31:0] f_lane(input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] res;
    case (sel)
      SEL_WORD: res = d;
      SEL_HI:   res = {16'd0, d[31:16]};
      SEL_LO:   res = {16'd0, d[15:0]};
      SEL_B3:   res = {24'd0, d[31:24]};
      SEL_B2:   res = {24'd0, d[23:16]};
      SEL_B1:   res = {24'd0, d[15:8]};
      SEL_B0:   res = {24'd0, d[7:0]};
      default:  res = 32'd0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] f_opnd(input logic [4:0] fld, input logic hit,
                                         input logic [31:0] q, input logic [31:0] wb);
    logic [31:0] res;
    if (fld == 5'd0) begin
      res = 32'd0;
    end else if (hit) begin
      res = wb;
    end else begin
      res = q;
    end
    return res;
  endfunction

  assign w_lane = f_lane(dwb_mx, sel_mx);

  always_comb begin
    w_wb = 32'd0;
    case (r_mux_mx)
      MUX_NONE: w_wb = 32'd0;
      MUX_ALU:  w_wb = alu_mx;
      MUX_SFR:  w_wb = sfr_mx;
      MUX_MUL:  w_wb = mul_mx;
      MUX_BSF:  w_wb = bsf_mx;
      MUX_LD:   w_wb = w_lane;
      MUX_XWB:  w_wb = xwb_mx;
      MUX_LNK:  w_wb = {rpc_mx, 2'b00};
      default:  w_wb = 32'd0;
    endcase
  end

  assign clr_busy  = (r_state == CLR_RUN);
  assign w_pipe_we = grst & dena & (r_mux_mx != MUX_NONE) & (r_rd_mx != 5'd0) & ~clr_busy;
  assign w_pipe_wa = f_idx(r_tid_mx, r_rd_mx);

  // The sweep owns the write port; reset edges themselves write nothing.
  assign w_clr_we = grst & clr_busy;
  assign w_ram_we = w_clr_we | w_pipe_we;
  assign w_ram_wa = w_clr_we ? r_cnt : w_pipe_wa;
  assign w_ram_wd = w_clr_we ? 32'd0 : w_wb;

  assign w_fd = ich_dat[25:21];
  assign w_fa = ich_dat[20:16];
  assign w_fb = ich_dat[15:11];
  assign w_ra = f_idx(gpha, w_fa);
  assign w_rb = f_idx(gpha, w_fb);
  assign w_rd = f_idx(gpha, w_fd);

  assign w_unused = ^{ich_dat[31:26], ich_dat[10:0]};

  aemb2_regbank_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk (gclk),
    .i_we  (w_ram_we),
    .i_wa  (w_ram_wa),
    .i_wd  (w_ram_wd),
    .i_ra  (w_ra),
    .i_rb  (w_rb),
    .i_rd  (w_rd),
    .o_qa  (w_qa),
    .o_qb  (w_qb),
    .o_qd  (w_qd)
  );

  assign w_hit_a = (AEMB_FWD != 0) && w_pipe_we && (w_ra == w_pipe_wa);
  assign w_hit_b = (AEMB_FWD != 0) && w_pipe_we && (w_rb == w_pipe_wa);
  assign w_hit_d = (AEMB_FWD != 0) && w_pipe_we && (w_rd == w_pipe_wa);

  assign w_opa_nx = f_opnd(w_fa, w_hit_a, w_qa, w_wb);
  assign w_opb_nx = f_opnd(w_fb, w_hit_b, w_qb, w_wb);
  assign w_opd_nx = f_opnd(w_fd, w_hit_d, w_qd, w_wb);

  always_ff @(posedge gclk) begin
    if (!grst) begin
      r_tid_of <= {TW{1'b0}};
      r_tid_ex <= {TW{1'b0}};
      r_tid_mx <= {TW{1'b0}};
      r_rd_mx  <= 5'd0;
      r_mux_mx <= MUX_NONE;
      r_opa    <= 32'd0;
      r_opb    <= 32'd0;
      r_opd    <= 32'd0;
    end else if (dena) begin
      r_tid_of <= gpha;
      r_tid_ex <= r_tid_of;
      r_tid_mx <= r_tid_ex;
      r_rd_mx  <= rd_ex;
      r_mux_mx <= mux_ex;
      r_opa    <= clr_busy ? 32'd0 : w_opa_nx;
      r_opb    <= clr_busy ? 32'd0 : w_opb_nx;
      r_opd    <= clr_busy ? 32'd0 : w_opd_nx;
    end
  end

  // Sweep runs regardless of dena so the bank is clean before the first issue.
  always_ff @(posedge gclk) begin
    if (!grst) begin
      r_state <= (AEMB_CLR != 0) ? CLR_RUN : CLR_IDLE;
      r_cnt   <= {AW{1'b0}};
    end else if (r_state == CLR_RUN) begin
      if (r_cnt == AW'(DEPTH - 1)) begin
        r_state <= CLR_IDLE;
      end
      r_cnt <= r_cnt + AW'(1);
    end
  end

  assign opa_if = r_opa;
  assign opb_if = r_opb;
  assign opd_if = r_opd;

endmodule

// File: doc/aemb2_regbank.md
# aemb2_regbank

Parametrised multi-thread general-purpose register bank for the AEMB2 pipeline. It replaces the single-option hyperthread register file with a bank of `AEMB_THR` thread contexts. It adds the following behaviour:
- integrated writeback source multiplexing with load-lane extraction;
- write-to-read bypass;
- a post-reset clearing sweep.

It decodes operand addresses from the fetched instruction and delivers registered operands to the OF stage.

## Interface
- `AEMB_THR`, 2 — thread contexts; 1, 2 or 4. `TW = max(1, clog2(AEMB_THR))`.
- `AEMB_CLR`, 1 — 1 enables the zero-fill sweep after reset; 0 skips it.
- `AEMB_FWD`, 1 — 1 enables the same-cycle write-to-read bypass.
- `gclk` in 1 — single clock, rising edge.
- `grst` in 1 — reset, synchronous, active-low.
- `dena` in 1 — pipeline advance enable.
- `gpha` in TW — thread ID of the instruction currently in IF.
- `ich_dat` in 32 — fetched instruction: rd=[25:21], ra=[20:16], rb=[15:11].
- `rd_ex` in 5 — destination register of the EX-stage instruction.
- `mux_ex` in 3 — writeback source of the EX-stage instruction.
- `sel_mx` in 4 — byte-lane select for load data in MX.
- `alu_mx`, `sfr_mx`, `mul_mx`, `bsf_mx`, `dwb_mx`, `xwb_mx` in 32 each — MX-stage result sources.
- `rpc_mx` in 30 [31:2] — link PC in MX.
- `opa_if`, `opb_if`, `opd_if` out 32 — registered operands for ra/rb/rd.
- `clr_busy` out 1 — sweep in progress; the pipeline must hold `dena` low while high.

## Operation
- Storage: `AEMB_THR*32` words. The entry index is {thread, reg}. r0 of every thread reads 0, and writes to r0 are discarded.
- Thread pipeline: `gpha` is registered on `dena` into `tid_of`, then `tid_ex`, then `tid_mx`. `rd_ex` and `mux_ex` are registered on `dena` into `rd_mx` and `mux_mx`.
- Writeback source selection by `mux_mx`:
  - 0 NONE;
  - 1 ALU;
  - 2 SFR;
  - 3 MUL;
  - 4 BSF;
  - 5 LD, which selects `dwb_mx` after lane extraction;
  - 6 XWB;
  - 7 LNK, which selects {`rpc_mx`, 2'b00}.
- Lane extraction from `dwb_mx`, zero-extended:
  - `sel_mx` 1111 gives the whole word;
  - 1100 gives [31:16];
  - 0011 gives [15:0];
  - 1000, 0100, 0010 and 0001 give bytes [31:24], [23:16], [15:8] and [7:0] respectively;
  - any other value gives 0.
- Write: on `gclk` with `dena`=1, `mux_mx`≠NONE, `rd_mx`≠0 and `clr_busy`=0, the entry {`tid_mx`, `rd_mx`} is written with the selected data.
- Read: on `gclk` with `dena`=1, each of `opa_if`/`opb_if`/`opd_if` captures entry {`gpha`, field}.
  - With `AEMB_FWD`=1, if the same entry is being written on that edge, the operand captures the write data instead.
  - With `AEMB_FWD`=0, the operand captures the old value.
- `dena`=0: all pipeline registers and operands hold, and no write occurs.
- Sweep FSM:
  - States: IDLE, CLR.
  - `grst`=0 moves the FSM to CLR and sets counter=0.
  - In CLR, one entry is zeroed per cycle, independent of `dena`, and the counter increments.
  - At counter = `AEMB_THR*32`−1 the last entry is written and the FSM moves to IDLE.
  - With `AEMB_CLR`=0, reset moves straight to IDLE, and the contents are undefined.
  - In CLR, pipeline writes are dropped, and operand captures return 0.
- Reset in the middle of a sweep restarts the sweep at counter 0.

## Timing
- Reset values:
  - `opa_if`, `opb_if`, `opd_if` = 0;
  - `tid_*` = 0;
  - `rd_mx` = 0;
  - `mux_mx` = NONE;
  - `clr_busy` = 1 (`AEMB_CLR`=1) or 0 (`AEMB_CLR`=0).
- Read latency: operands are valid 1 cycle after the `dena` edge that samples `ich_dat`.
- Write latency: a write is visible to a capture on the next `dena` edge, or on the same edge when `AEMB_FWD`=1.
- Sweep duration: `clr_busy` falls `AEMB_THR*32` cycles after the first cycle with `grst`=1.
- A write to thread t is never visible to a read of thread u≠t.

## Structure
- Package `aemb2_pkg` holds:
  - the `mux_*` encodings (NONE..LNK);
  - `sel_*` lane constants;
  - the `TW` function;
  - the FSM state enum.
- One sub-module, `aemb2_regbank_ram`: a 1W3R array of depth `AEMB_THR*32`, with synchronous write and asynchronous read. It is replicable as three 1W1R RAMs for FPGA inference.
- The top level holds the thread pipeline, the writeback mux, lane extraction, the bypass and the sweep FSM.

## Test plan
- Reset sweep: hold `grst` low for 3 cycles, then release with `AEMB_THR`=2. Required: `clr_busy` stays high for exactly 64 cycles, and every register then reads 0.
- Basic write/read: write ALU value 0xDEADBEEF to r5 of thread 1. Then read ra=5 with `gpha`=1 and with `gpha`=0. Required: 0xDEADBEEF for thread 1, 0 for thread 0.
- Lane extraction: set `mux_mx`=LD and `dwb_mx`=0x11223344.
  - `sel_mx` 0100 → 0x00000022;
  - `sel_mx` 0011 → 0x00003344;
  - `sel_mx` 0110 → 0.
- Bypass: write r7=0x5 on the same edge that captures rb=7 for the same thread. Required: `opb_if`=0x5 with `AEMB_FWD`=1, and the old value with `AEMB_FWD`=0.
- r0 and stall: write 0xFFFF to r0 while `dena`=0 for 2 cycles, then with `dena`=1. Required: r0 still reads 0, and operands hold their values during the stall.
- Mid-sweep reset: pulse `grst` low at sweep cycle 20. Required: the sweep restarts, and `clr_busy` stays high for a full 64 cycles after the release.
